arb_mux: RTL and testbench

Parametrised N-channel round-robin arbitrating multiplexer with valid/ready handshakes and a registered output stage. It merges several producer streams, such as register-file write requests or load/store sources, onto one consumer port. It replaces fixed 2/4/8/16-way combinational muxing wherever sources are independent and may stall. The output carries the winning channel index so downstream logic can route responses.

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/arb_mux.sv | 75 +++++++
 tb/tb_arb_mux.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared index helpers and arbiter state type for arb_mux.
package mux_pkg;
  localparam int MAX_CH_BITS = 4;
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [MAX_CH_BITS-1:0] wrap_inc(input logic [MAX_CH_BITS-1:0] idx, input int n);
    return (int'(idx) + 1 >= n) ? '0 : idx + MAX_CH_BITS'(1);
  endfunction
  typedef struct packed {
    logic [MAX_CH_BITS-1:0] rr_ptr;
    logic                   locked;
    logic [MAX_CH_BITS-1:0] lock_ch;
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting at rr_ptr, optionally pinned to lock_ch.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  localparam int CH_BITS = ch_bits(NUM_CH)
) (
  input  logic [NUM_CH-1:0]      req,
  input  logic [MAX_CH_BITS-1:0] rr_ptr,
  input  logic                   lock,
  input  logic [MAX_CH_BITS-1:0] lock_ch,
  output logic [NUM_CH-1:0]      grant,
  output logic [CH_BITS-1:0]     grant_idx
);
  logic [NUM_CH-1:0]   w_req;
  logic [2*NUM_CH-1:0] w_rot;
  logic [MAX_CH_BITS:0] w_s;
  assign w_req = lock ? (req & (NUM_CH'(1) << lock_ch)) : req;
  assign w_rot = {w_req, w_req} >> rr_ptr;
  // scan from the far end so the nearest requester in search order wins
  always_comb begin
    grant = '0;
    grant_idx = '0;
    w_s = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_s = {1'b0, rr_ptr} + (MAX_CH_BITS+1)'(k);
        w_s = (w_s >= (MAX_CH_BITS+1)'(NUM_CH)) ? w_s - (MAX_CH_BITS+1)'(NUM_CH) : w_s;
        grant = NUM_CH'(1) << w_s;
        grant_idx = CH_BITS'(w_s);
      end
    end
  end
endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel round-robin arbitrating mux with registered output stage.
// Define ARB_MUX_LOCK_EN to add in_last/out_last and hold the grant for a whole burst.
module arb_mux
  import mux_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int DATA_BITS = 8,
  localparam int CH_BITS   = ch_bits(NUM_CH)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_CH-1:0]                 in_valid,
  output logic [NUM_CH-1:0]                 in_ready,
  input  logic [NUM_CH-1:0][DATA_BITS-1:0]  in_data,
`ifdef ARB_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]                 in_last,
  output logic                              out_last,
`endif
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_BITS-1:0]              out_data,
  output logic [CH_BITS-1:0]                out_ch
);
  arb_state_t           r_st;
  logic                 r_out_valid;
  logic [DATA_BITS-1:0] r_out_data;
  logic [CH_BITS-1:0]   r_out_ch;
  logic [NUM_CH-1:0]    w_grant;
  logic [CH_BITS-1:0]   w_g;
  logic                 w_load_ok;
  logic                 w_acc;
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (in_valid),
    .rr_ptr    (r_st.rr_ptr),
    .lock      (r_st.locked),
    .lock_ch   (r_st.lock_ch),
    .grant     (w_grant),
    .grant_idx (w_g)
  );
  assign w_load_ok = !r_out_valid || out_ready;
  assign in_ready  = w_grant & {NUM_CH{w_load_ok}};
  assign w_acc     = |(in_valid & in_ready);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
`ifdef ARB_MUX_LOCK_EN
  logic r_out_last;
  assign out_last = r_out_last;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
`ifdef ARB_MUX_LOCK_EN
      r_out_last  <= 1'b0;
`endif
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[w_g];
      r_out_ch    <= w_g;
`ifdef ARB_MUX_LOCK_EN
      r_out_last  <= in_last[w_g];
      r_st.locked <= !in_last[w_g];
      r_st.lock_ch <= MAX_CH_BITS'(w_g);
      if (in_last[w_g]) r_st.rr_ptr <= wrap_inc(MAX_CH_BITS'(w_g), NUM_CH);
`else
      r_st.rr_ptr <= wrap_inc(MAX_CH_BITS'(w_g), NUM_CH);
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed stimulus with queued expectations popped by per-DUT output monitors.
module tb_arb_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic            reset_n;
  logic [3:0]      in_valid, in_ready;
  logic [3:0][7:0] in_data;
  logic            out_valid, out_ready;
  logic [7:0]      out_data;
  logic [1:0]      out_ch;
  logic [4:0]      v5, r5;
  logic [4:0][7:0] d5;
  logic            ov5, or5;
  logic [7:0]      od5;
  logic [2:0]      oc5;
`ifdef ARB_MUX_LOCK_EN
  logic [3:0] in_last;
  logic       out_last;
  logic [4:0] l5;
  logic       ol5;
`endif
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {logic [3:0] ch; logic [7:0] data; logic last;} exp_t;
  exp_t q[$];
  exp_t q5[$];

  arb_mux dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef ARB_MUX_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
  );
  arb_mux #(.NUM_CH(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .in_valid(v5), .in_ready(r5), .in_data(d5),
`ifdef ARB_MUX_LOCK_EN
    .in_last(l5), .out_last(ol5),
`endif
    .out_valid(ov5), .out_ready(or5), .out_data(od5), .out_ch(oc5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [3:0] c, input logic [7:0] d, input logic l);
    q.push_back('{c, d, l});
  endtask
  task automatic push5(input logic [3:0] c, input logic [7:0] d);
    q5.push_back('{c, d, 1'b1});
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && (q.size() != 0 || q5.size() != 0); i++) step();
    chk("drain_left", 32'(q.size() + q5.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb4_unexpected: got ch %0d data 0x%0h, required no beat", out_ch, out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb4_ch", 32'(out_ch), 32'(e.ch));
        chk("sb4_data", 32'(out_data), 32'(e.data));
`ifdef ARB_MUX_LOCK_EN
        chk("sb4_last", 32'(out_last), 32'(e.last));
`endif
      end
    end
  end
  always @(negedge clk) begin
    if (reset_n && ov5 && or5) begin
      if (q5.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb5_unexpected: got ch %0d data 0x%0h, required no beat", oc5, od5);
      end else begin
        exp_t e;
        e = q5.pop_front();
        chk("sb5_ch", 32'(oc5), 32'(e.ch));
        chk("sb5_data", 32'(od5), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    in_data = {8'h43, 8'h32, 8'h21, 8'h10};
    v5 = '0;
    or5 = 1'b1;
    d5 = {8'h54, 8'h53, 8'h52, 8'h51, 8'h50};
`ifdef ARB_MUX_LOCK_EN
    in_last = '1;
    l5 = '1;
`endif
    repeat (2) step();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_rr_ptr", 32'(dut.r_st.rr_ptr), 32'd0);
    chk("rst_out_valid5", 32'(ov5), 32'd0);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    // all four channels: strict rotation, one beat per cycle
    in_valid = 4'hF;
    push(0, 8'h10, 1); push(1, 8'h21, 1); push(2, 8'h32, 1);
    push(3, 8'h43, 1); push(0, 8'h10, 1); push(1, 8'h21, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) chk("thru_valid", 32'(out_valid), 32'd1);
      step();
    end
    in_valid = '0;
    drain();
    // lone channel 2
    in_data[2] = 8'hA5;
    in_valid = 4'b0100;
    repeat (3) push(2, 8'hA5, 1);
    repeat (3) begin
      @(negedge clk);
      chk("ch2_ready", 32'(in_ready), 32'b0100);
      step();
    end
    in_valid = '0;
    chk("ch2_rr_ptr", 32'(dut.r_st.rr_ptr), 32'd3);
    drain();
    // stall with channels 0 and 1 pending, rr_ptr = 1
    in_valid = 4'b0001;
    out_ready = 1'b0;
    push(0, 8'h10, 1); push(1, 8'h21, 1);
    step();
    in_valid = 4'b0011;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_data", 32'(out_data), 32'h10);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("resume_ready", 32'(in_ready), 32'b0010);
    step();
    in_valid = '0;
    drain();
    // five channels: pointer wraps from 4 to 0
    v5 = 5'b01000;
    push5(3, 8'h53);
    step();
    v5 = 5'b11000;
    push5(4, 8'h54); push5(3, 8'h53); push5(4, 8'h54);
    repeat (3) step();
    v5 = '0;
    chk("n5_rr_ptr", 32'(dut5.r_st.rr_ptr), 32'd0);
    drain();
    // asynchronous reset discards a held beat; rr_ptr would otherwise be 2
    out_ready = 1'b0;
    in_data[1] = 8'h3C;
    in_valid = 4'b0010;
    step();
    in_valid = '0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_data", 32'(out_data), 32'h3C);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_ch", 32'(out_ch), 32'd0);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    in_data[1] = 8'h21;
    in_valid = 4'b0110;
    push(1, 8'h21, 1);
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'b0010);
    step();
    in_valid = '0;
    drain();
`ifdef ARB_MUX_LOCK_EN
    // burst on channel 1 holds the grant against channel 0
    in_valid = 4'b0001;
    push(0, 8'h10, 1);
    step();
    in_valid = 4'b0011;
    in_last = 4'b0001;
    in_data[1] = 8'hB1;
    push(1, 8'hB1, 0);
    step();
    in_valid = 4'b0001;
    @(negedge clk);
    chk("lock_hold_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 4'b0011;
    in_data[1] = 8'hB2;
    push(1, 8'hB2, 0);
    @(negedge clk);
    chk("lock_b2_ready", 32'(in_ready), 32'b0010);
    step();
    in_data[1] = 8'hB3;
    in_last = 4'b0011;
    push(1, 8'hB3, 1);
    step();
    in_valid = 4'b0001;
    push(0, 8'h10, 1);
    @(negedge clk);
    chk("unlock_ready", 32'(in_ready), 32'b0001);
    step();
    in_valid = '0;
    drain();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
